// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled, mid-bit sampled 8E1 frames
// (start, 8 data bits LSB first, even parity, stop) with its own baud divider.
module uart_receiver #(
    parameter int CLK_FREQ    = 50000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_EN,
    input  logic [2:0] baud_select,
    input  logic       Rx_D,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR,
    output logic       Rx_BUSY,
    output logic [2:0] dbg_state
);

    // Handshake: Rx_VALID is a single-cycle strobe with no back-pressure;
    // Rx_DATA and the error flags are stable from that cycle until the
    // next confirmed start bit.

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [13:0]            cnt_q, cnt_d;
    logic [3:0]             tc_q, tc_d;
    logic [2:0]             idx_q, idx_d;
    logic [2:0]             baud_q, baud_d;
    logic [7:0]             shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   armed_q, armed_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   pflag_q, pflag_d;
    logic                   fflag_q, fflag_d;
    logic                   tick;

    // Clocks per 1/16 bit for each baud code (50 MHz system clock).
    function automatic logic [13:0] div_of(input logic [2:0] sel);
        case (sel)
            3'd0:    div_of = 14'd10417;
            3'd1:    div_of = 14'd2604;
            3'd2:    div_of = 14'd651;
            3'd3:    div_of = 14'd326;
            3'd4:    div_of = 14'd163;
            3'd5:    div_of = 14'd81;
            3'd6:    div_of = 14'd54;
            default: div_of = 14'd27;
        endcase
    endfunction

    // Metastability synchronizer for the asynchronous serial line, idle-high preset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], Rx_D};
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // Sample tick fires once every DIV clocks while a frame is in progress.
    assign tick = (state_q != IDLE) && (cnt_q == 14'd0);

    // Next-state, counters, shift register and output registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = tc_q;
        idx_d   = idx_q;
        baud_d  = baud_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        armed_d = armed_q;
        data_d  = data_q;
        valid_d = 1'b0;
        pflag_d = pflag_q;
        fflag_d = fflag_q;

        if (state_q != IDLE) begin
            cnt_d = (cnt_q == 14'd0) ? div_of(baud_q) - 14'd1 : cnt_q - 14'd1;
        end

        if (!Rx_EN) begin
            state_d = IDLE;
            cnt_d   = '0;
            tc_d    = '0;
            idx_d   = '0;
            armed_d = rxs;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    tc_d  = '0;
                    idx_d = '0;
                    // armed only after the line has been seen high, so a held break never restarts
                    if (armed_q && !rxs) begin
                        state_d = START;
                        baud_d  = baud_select;
                        cnt_d   = div_of(baud_select) - 14'd1;
                        armed_d = 1'b0;
                    end else begin
                        armed_d = rxs;
                    end
                end
                START: if (tick) begin
                    if (tc_q == 4'd7) begin
                        tc_d = '0;
                        if (rxs) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            idx_d   = '0;
                            pflag_d = 1'b0;
                            fflag_d = 1'b0;
                        end
                    end else begin
                        tc_d = tc_q + 4'd1;
                    end
                end
                DATA: if (tick) begin
                    if (tc_q == 4'd15) begin
                        tc_d           = '0;
                        shift_d[idx_q] = rxs;
                        if (idx_q == 3'd7) state_d = PARITY;
                        else               idx_d   = idx_q + 3'd1;
                    end else begin
                        tc_d = tc_q + 4'd1;
                    end
                end
                PARITY: if (tick) begin
                    if (tc_q == 4'd15) begin
                        tc_d    = '0;
                        perr_d  = rxs ^ (^shift_q);
                        state_d = STOP;
                    end else begin
                        tc_d = tc_q + 4'd1;
                    end
                end
                STOP: if (tick) begin
                    if (tc_q == 4'd15) begin
                        tc_d    = '0;
                        data_d  = shift_q;
                        pflag_d = perr_q;
                        fflag_d = ~rxs;
                        valid_d = ~perr_q & rxs;
                        armed_d = rxs;
                        state_d = IDLE;
                    end else begin
                        tc_d = tc_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tc_q    <= '0;
            idx_q   <= '0;
            baud_q  <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            armed_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pflag_q <= 1'b0;
            fflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            idx_q   <= idx_d;
            baud_q  <= baud_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pflag_q <= pflag_d;
            fflag_q <= fflag_d;
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_PERROR = pflag_q;
    assign Rx_FERROR = fflag_q;
    assign Rx_BUSY   = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frame driver, reference model feeding an expected
// queue, and a monitor that pops and compares on every reported frame.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_en = 1'b0;
    logic [2:0] baud_sel = 3'd7;
    logic       rx_d = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_perror, rx_ferror, rx_busy;
    logic [2:0] dbg_state;

    int total = 0;
    int bad = 0;
    int pushed = 0;
    int seen = 0;

    // {valid, ferr, perr, data}
    logic [10:0] exp_q[$];

    uart_receiver #(.CLK_FREQ(50000000), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset_n), .Rx_EN(rx_en), .baud_select(baud_sel),
        .Rx_D(rx_d), .Rx_DATA(rx_data), .Rx_VALID(rx_valid),
        .Rx_PERROR(rx_perror), .Rx_FERROR(rx_ferror), .Rx_BUSY(rx_busy),
        .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #(150000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int div_clks(input int sel);
        int tab[8] = '{10417, 2604, 651, 326, 163, 81, 54, 27};
        return tab[sel];
    endfunction

    function automatic logic even_par(input logic [7:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    // Frame bits in line order: index 0 is the start bit.
    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic expect_frame(input logic [7:0] d, input logic p, input logic s);
        logic perr;
        perr = (p != even_par(d));
        exp_q.push_back({(!perr && s), !s, perr, d});
        pushed++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive half-bit slots [from, to) of a frame.
    task automatic send_half(input logic [10:0] fr, input int from, input int to, input int bclk);
        logic [10:0] f;
        f = fr;
        for (int i = from; i < to; i++) begin
            rx_d = f[i / 2];
            wait_clks(bclk / 2);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int bclk);
        expect_frame(d, p, s);
        send_half(make_frame(d, p, s), 0, 22, bclk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic p_prev, f_prev, v_prev, ev;
        logic [10:0] e;
        p_prev = 1'b0; f_prev = 1'b0; v_prev = 1'b0;
        forever begin
            @(negedge clk);
            ev = reset_n && (rx_valid || (rx_perror && !p_prev) || (rx_ferror && !f_prev));
            if (reset_n && rx_valid && v_prev) begin
                total++; bad++;
                $display("FAIL valid_width: Rx_VALID high for more than one clk");
            end
            if (ev) begin
                seen++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_frame: got {v,f,p,data}=0x%0h with nothing expected",
                             {rx_valid, rx_ferror, rx_perror, rx_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({rx_valid, rx_ferror, rx_perror, rx_data} !== e) begin
                        bad++;
                        $display("FAIL frame: got {v,f,p,data}=0x%0h expected 0x%0h",
                                 {rx_valid, rx_ferror, rx_perror, rx_data}, e);
                    end
                end
            end
            p_prev = rx_perror; f_prev = rx_ferror; v_prev = rx_valid;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int bclk;
        int busy_seen;
        logic [7:0] d;
        logic p, s;

        bclk = 16 * div_clks(7);

        // reset state
        wait_clks(5);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_perr", {31'd0, rx_perror}, 32'd0);
        check("rst_ferr", {31'd0, rx_ferror}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);

        // idle line with receiver enabled
        reset_n = 1'b1;
        rx_en = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rx_busy || rx_valid || rx_perror || rx_ferror) busy_seen++;
        end
        wait_clks(1);
        check("idle_quiet", busy_seen, 0);

        // good frame, parity error, framing error with held break
        send_frame(8'hA5, 1'b0, 1'b1, bclk);
        wait_clks(bclk);
        send_frame(8'h01, 1'b0, 1'b1, bclk);
        wait_clks(bclk);
        send_frame(8'h3C, even_par(8'h3C), 1'b0, bclk);
        rx_d = 1'b0;
        wait_clks(5 * bclk);
        check("break_not_busy", {31'd0, rx_busy}, 32'd0);
        rx_d = 1'b1;
        wait_clks(2 * bclk);

        // false start: short low glitch
        rx_d = 1'b0;
        wait_clks(50);
        check("glitch_busy", {31'd0, rx_busy}, 32'd1);
        wait_clks(50);
        rx_d = 1'b1;
        wait_clks(bclk);
        check("glitch_idle", {31'd0, rx_busy}, 32'd0);
        check("glitch_data", {24'd0, rx_data}, 32'h3C);

        // abort by Rx_EN during data bit 4
        send_half(make_frame(8'hC3, even_par(8'hC3), 1'b1), 0, 11, bclk);
        rx_en = 1'b0;
        rx_d = 1'b1;
        wait_clks(3);
        check("en_abort_busy", {31'd0, rx_busy}, 32'd0);
        wait_clks(20);
        rx_en = 1'b1;
        wait_clks(bclk);
        send_frame(8'h5A, even_par(8'h5A), 1'b1, bclk);
        wait_clks(bclk);

        // abort by reset during data bit 4
        send_half(make_frame(8'h96, even_par(8'h96), 1'b1), 0, 11, bclk);
        reset_n = 1'b0;
        rx_d = 1'b1;
        wait_clks(5);
        check("rst_abort_data", {24'd0, rx_data}, 32'd0);
        check("rst_abort_busy", {31'd0, rx_busy}, 32'd0);
        reset_n = 1'b1;
        wait_clks(bclk);
        send_frame(8'h5A, even_par(8'h5A), 1'b1, bclk);
        wait_clks(bclk);

        // baud_select change mid-frame is ignored until the next frame
        expect_frame(8'h69, even_par(8'h69), 1'b1);
        send_half(make_frame(8'h69, even_par(8'h69), 1'b1), 0, 3, bclk);
        baud_sel = 3'd6;
        send_half(make_frame(8'h69, even_par(8'h69), 1'b1), 3, 22, bclk);
        baud_sel = 3'd7;
        wait_clks(bclk);

        // back-to-back frames, single stop bit, no idle gap
        send_frame(8'h00, even_par(8'h00), 1'b1, bclk);
        send_frame(8'hFF, even_par(8'hFF), 1'b1, bclk);
        send_frame(8'h55, even_par(8'h55), 1'b1, bclk);
        wait_clks(bclk);

        // randomized frames with occasional parity / stop errors
        for (int n = 0; n < 4; n++) begin
            d = 8'($urandom_range(0, 255));
            p = even_par(d) ^ ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 3) != 0);
            send_frame(d, p, s, bclk);
            rx_d = 1'b1;
            wait_clks(2 * bclk);
        end

        // drain
        wait_clks(100);
        check("queue_empty", exp_q.size(), 0);
        check("frame_count", seen, pushed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
